// File: rtl/rv_wb_arbiter_pkg.sv
// rv_pkg: shared constants and types for the writeback path.
//   XLEN     - architectural data width
//   REG_AW   - register address width (32 architectural registers)
//   wb_req_t - one writeback request (destination register + data)
package rv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/rv_wb_arbiter_if.sv
// rv_wb_arbiter_if: writeback request bus between NUM_REQ requesters and
// the regfile write-port arbiter. Vectors are packed per requester, lane i
// occupying bits [i*W +: W].
//   req_valid  requester -> arbiter  write pending, per requester
//   req_ready  arbiter -> requester  grant this cycle (handshake = valid & ready)
//   req_addr   requester -> arbiter  destination register per requester
//   req_data   requester -> arbiter  write data per requester
// modport master: requester side; modport slave: arbiter side.
interface rv_wb_arbiter_if
  import rv_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN_P  = XLEN,
  parameter int AW      = REG_AW
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*AW-1:0]     req_addr;
  logic [NUM_REQ*XLEN_P-1:0] req_data;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/rv_rr_arbiter.sv
// rv_rr_arbiter: round-robin arbiter over NUM_REQ valid lines.
//   clk_i        in   clock, rising edge
//   rst_ni       in   async reset, active low
//   valid_i      in   request vector
//   grant_o      out  one-hot grant (combinational from valid_i and pointer)
//   grant_idx_o  out  index of the granted requester
//   grant_vld_o  out  a grant is being issued this cycle
// Every grant is an accepted handshake, so the pointer advances to
// (granted index + 1) mod NUM_REQ whenever grant_vld_o is high.
module rv_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] valid_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PW-1:0]      grant_idx_o,
  output logic               grant_vld_o
);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant;
  logic [PW-1:0]      idx;
  logic               found;
  int                 j;

  // Scan from the pointer, wrapping NUM_REQ-1 -> 0; first valid wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr_q) + i) % NUM_REQ;
      if (!found && valid_i[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = PW'(j);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = PW'((int'(idx) + 1) % NUM_REQ);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign grant_o     = grant;
  assign grant_idx_o = idx;
  assign grant_vld_o = found;

endmodule

// File: rtl/rv_wb_arbiter.sv
// rv_wb_arbiter: shares the single regfile write port among NUM_REQ
// writeback sources and keeps a per-register busy scoreboard for decode.
//   clk_i            in   clock, rising edge
//   rst_ni           in   async reset, active low
//   wb               if   writeback request bus (slave side)
//   issue_valid_i    in   decode issues an instruction writing issue_rd_i
//   issue_rd_i       in   destination of the issuing instruction
//   issue_ready_o    out  low when issue_rd_i is already busy (WAW stall)
//   rs1/rs2_addr_i   in   decode source registers
//   rs1/rs2_busy_o   out  source has a pending write
//   rf_write_en_o    out  regfile write enable (registered)
//   rf_write_addr_o  out  regfile write address (registered)
//   rf_write_data_o  out  regfile write data (registered)
// A handshake in cycle N presents the write in cycle N+1; x0 writes are
// accepted but never enable the regfile.
module rv_wb_arbiter
  import rv_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN_P  = XLEN,
  parameter int AW      = REG_AW
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  rv_wb_arbiter_if.slave    wb,
  input  logic              issue_valid_i,
  input  logic [AW-1:0]     issue_rd_i,
  output logic              issue_ready_o,
  input  logic [AW-1:0]     rs1_addr_i,
  input  logic [AW-1:0]     rs2_addr_i,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o,
  output logic              rf_write_en_o,
  output logic [AW-1:0]     rf_write_addr_o,
  output logic [XLEN_P-1:0] rf_write_data_o
);

  localparam int PW   = $clog2(NUM_REQ);
  localparam int NREG = 1 << AW;

  logic [NUM_REQ-1:0] gnt;
  logic [PW-1:0]      gnt_idx;
  logic               gnt_vld;
  logic [AW-1:0]      sel_addr;
  logic [XLEN_P-1:0]  sel_data;

  logic               wr_en_q;
  logic [AW-1:0]      wr_addr_q;
  logic [XLEN_P-1:0]  wr_data_q;

  logic [NREG-1:0]    busy_q, busy_d;
  logic               issue_set;

  rv_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_rr (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .valid_i     (wb.req_valid),
    .grant_o     (gnt),
    .grant_idx_o (gnt_idx),
    .grant_vld_o (gnt_vld)
  );

  // Ready is forced low while reset is asserted so no handshake can be
  // seen by a requester during reset.
  assign wb.req_ready = gnt & {NUM_REQ{rst_ni}};

  always_comb begin
    sel_addr = wb.req_addr[int'(gnt_idx)*AW +: AW];
    sel_data = wb.req_data[int'(gnt_idx)*XLEN_P +: XLEN_P];
  end

  // Address/data hold their last value on idle cycles; only the enable
  // qualifies the write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= gnt_vld && (sel_addr != '0);
      if (gnt_vld) begin
        wr_addr_q <= sel_addr;
        wr_data_q <= sel_data;
      end
    end
  end

  assign rf_write_en_o   = wr_en_q;
  assign rf_write_addr_o = wr_addr_q;
  assign rf_write_data_o = wr_data_q;

  // A write landing this cycle to issue_rd_i frees it in time for the
  // new issue, so the issue is not stalled.
  assign issue_ready_o = !busy_q[issue_rd_i] || (issue_rd_i == '0) ||
                         (wr_en_q && (wr_addr_q == issue_rd_i));
  assign issue_set     = issue_valid_i && issue_ready_o && (issue_rd_i != '0);

  // Clear first, then set: same-edge set and clear of one address leaves it busy.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_q) begin
      busy_d[wr_addr_q] = 1'b0;
    end
    if (issue_set) begin
      busy_d[issue_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rs1_busy_o = busy_q[rs1_addr_i] && (rs1_addr_i != '0);
  assign rs2_busy_o = busy_q[rs2_addr_i] && (rs2_addr_i != '0);

endmodule

// File: tb/tb_rv_wb_arbiter.sv
// tb_rv_wb_arbiter: directed bench for rv_wb_arbiter with two requesters.
// Inputs change 1 ns after the rising edge; outputs are checked in the
// same settled window, before the next rising edge.
module tb_rv_wb_arbiter;
  import rv_pkg::*;

  localparam int NR = 2;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             issue_valid_i;
  logic [4:0]       issue_rd_i;
  logic             issue_ready_o;
  logic [4:0]       rs1_addr_i;
  logic [4:0]       rs2_addr_i;
  logic             rs1_busy_o;
  logic             rs2_busy_o;
  logic             rf_write_en_o;
  logic [4:0]       rf_write_addr_o;
  logic [31:0]      rf_write_data_o;

  int checks = 0;
  int errors = 0;

  rv_wb_arbiter_if #(.NUM_REQ(NR), .XLEN_P(32), .AW(5)) wb ();

  rv_wb_arbiter #(.NUM_REQ(NR), .XLEN_P(32), .AW(5)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .wb              (wb),
    .issue_valid_i   (issue_valid_i),
    .issue_rd_i      (issue_rd_i),
    .issue_ready_o   (issue_ready_o),
    .rs1_addr_i      (rs1_addr_i),
    .rs2_addr_i      (rs2_addr_i),
    .rs1_busy_o      (rs1_busy_o),
    .rs2_busy_o      (rs2_busy_o),
    .rf_write_en_o   (rf_write_en_o),
    .rf_write_addr_o (rf_write_addr_o),
    .rf_write_data_o (rf_write_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int lane, input logic v, input wb_req_t r);
    wb.req_valid[lane]           = v;
    wb.req_addr[lane*5 +: 5]     = r.addr;
    wb.req_data[lane*32 +: 32]   = r.data;
  endtask

  wb_req_t r0, r1;

  initial begin
    rst_ni        = 1'b0;
    wb.req_valid  = '0;
    wb.req_addr   = '0;
    wb.req_data   = '0;
    issue_valid_i = 1'b0;
    issue_rd_i    = '0;
    rs1_addr_i    = '0;
    rs2_addr_i    = '0;

    // Reset state
    #2;
    chk_eq("rst_en",    32'(rf_write_en_o), 32'h0);
    chk_eq("rst_addr",  32'(rf_write_addr_o), 32'h0);
    chk_eq("rst_data",  rf_write_data_o, 32'h0);
    tick();
    tick();
    rst_ni = 1'b1;
    tick();

    // Two requesters valid together: grant 0 then 1, writes x5 then x6
    r0 = '{addr: 5'd5, data: 32'hA5A5_0001};
    r1 = '{addr: 5'd6, data: 32'h0000_00FF};
    set_req(0, 1'b1, r0);
    set_req(1, 1'b1, r1);
    #1;
    chk_eq("t2_rdy_c0", 32'(wb.req_ready), 32'h1);
    tick();
    wb.req_valid[0] = 1'b0;
    #1;
    chk_eq("t2_en_c1",   32'(rf_write_en_o), 32'h1);
    chk_eq("t2_addr_c1", 32'(rf_write_addr_o), 32'h5);
    chk_eq("t2_data_c1", rf_write_data_o, 32'hA5A5_0001);
    chk_eq("t2_rdy_c1",  32'(wb.req_ready), 32'h2);
    tick();
    wb.req_valid[1] = 1'b0;
    #1;
    chk_eq("t2_en_c2",   32'(rf_write_en_o), 32'h1);
    chk_eq("t2_addr_c2", 32'(rf_write_addr_o), 32'h6);
    chk_eq("t2_data_c2", rf_write_data_o, 32'h0000_00FF);
    chk_eq("t2_rdy_c2",  32'(wb.req_ready), 32'h0);
    tick();
    chk_eq("t2_en_c3",   32'(rf_write_en_o), 32'h0);
    wb.req_valid = 2'b11;
    #1;
    chk_eq("t2_ptr_back", 32'(wb.req_ready), 32'h1);

    // Continuous contention: alternate 0,1,0,1...
    for (int k = 0; k < 8; k++) begin
      chk_eq($sformatf("t3_rdy_%0d", k), 32'(wb.req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      chk_eq($sformatf("t3_addr_%0d", k), 32'(rf_write_addr_o), (k % 2 == 0) ? 32'h5 : 32'h6);
    end
    wb.req_valid = 2'b00;
    tick();

    // Scoreboard set by issue, cleared the cycle after the write lands
    rs1_addr_i    = 5'd7;
    rs2_addr_i    = 5'd7;
    issue_valid_i = 1'b1;
    issue_rd_i    = 5'd7;
    #1;
    chk_eq("t4_iss_rdy", 32'(issue_ready_o), 32'h1);
    chk_eq("t4_rs1_pre", 32'(rs1_busy_o), 32'h0);
    tick();
    issue_valid_i = 1'b0;
    #1;
    chk_eq("t4_rs1_set", 32'(rs1_busy_o), 32'h1);
    chk_eq("t4_rs2_set", 32'(rs2_busy_o), 32'h1);
    r0 = '{addr: 5'd7, data: 32'h0000_0077};
    set_req(0, 1'b1, r0);
    #1;
    chk_eq("t4_rdy", 32'(wb.req_ready), 32'h1);
    tick();
    wb.req_valid = 2'b00;
    #1;
    chk_eq("t4_en",       32'(rf_write_en_o), 32'h1);
    chk_eq("t4_addr",     32'(rf_write_addr_o), 32'h7);
    chk_eq("t4_rs1_wr",   32'(rs1_busy_o), 32'h1);
    tick();
    chk_eq("t4_rs1_clr",  32'(rs1_busy_o), 32'h0);
    chk_eq("t4_rs2_clr",  32'(rs2_busy_o), 32'h0);

    // x0 write handshaked but never enabled; x0 never busy
    r0 = '{addr: 5'd0, data: 32'hDEAD_BEEF};
    set_req(0, 1'b1, r0);
    #1;
    chk_eq("t5_rdy", 32'(wb.req_ready), 32'h1);
    tick();
    wb.req_valid = 2'b00;
    #1;
    chk_eq("t5_en", 32'(rf_write_en_o), 32'h0);
    issue_valid_i = 1'b1;
    issue_rd_i    = 5'd0;
    #1;
    chk_eq("t5_iss_rdy", 32'(issue_ready_o), 32'h1);
    tick();
    issue_valid_i = 1'b0;
    rs1_addr_i    = 5'd0;
    #1;
    chk_eq("t5_rs1_x0", 32'(rs1_busy_o), 32'h0);
    chk_eq("t5_iss_x0", 32'(issue_ready_o), 32'h1);

    // WAW stall, released by a same-cycle write; set wins over clear
    issue_valid_i = 1'b1;
    issue_rd_i    = 5'd9;
    rs1_addr_i    = 5'd9;
    tick();
    issue_valid_i = 1'b0;
    #1;
    chk_eq("t6_iss_stall", 32'(issue_ready_o), 32'h0);
    chk_eq("t6_rs1_busy",  32'(rs1_busy_o), 32'h1);
    r1 = '{addr: 5'd9, data: 32'h0000_0099};
    set_req(1, 1'b1, r1);
    #1;
    chk_eq("t6_rdy", 32'(wb.req_ready), 32'h2);
    tick();
    wb.req_valid = 2'b00;
    #1;
    chk_eq("t6_en",   32'(rf_write_en_o), 32'h1);
    chk_eq("t6_addr", 32'(rf_write_addr_o), 32'h9);
    issue_valid_i = 1'b1;
    #1;
    chk_eq("t6_iss_bypass", 32'(issue_ready_o), 32'h1);
    tick();
    issue_valid_i = 1'b0;
    #1;
    chk_eq("t6_set_wins", 32'(rs1_busy_o), 32'h1);
    r0 = '{addr: 5'd9, data: 32'h0000_0999};
    set_req(0, 1'b1, r0);
    #1;
    chk_eq("t6_rdy2", 32'(wb.req_ready), 32'h1);
    tick();
    wb.req_valid = 2'b00;
    tick();
    chk_eq("t6_rs1_clr", 32'(rs1_busy_o), 32'h0);

    // Reset asserted while a write is being presented
    issue_valid_i = 1'b1;
    issue_rd_i    = 5'd3;
    rs1_addr_i    = 5'd3;
    tick();
    issue_valid_i = 1'b0;
    r0 = '{addr: 5'd3, data: 32'h0000_0033};
    set_req(0, 1'b1, r0);
    tick();
    wb.req_valid = 2'b10;
    #1;
    chk_eq("t1_en_pre",  32'(rf_write_en_o), 32'h1);
    chk_eq("t1_rs1_pre", 32'(rs1_busy_o), 32'h1);
    rst_ni = 1'b0;
    #1;
    chk_eq("t1_en_rst",   32'(rf_write_en_o), 32'h0);
    chk_eq("t1_addr_rst", 32'(rf_write_addr_o), 32'h0);
    chk_eq("t1_rs1_rst",  32'(rs1_busy_o), 32'h0);
    chk_eq("t1_rdy_rst",  32'(wb.req_ready), 32'h0);
    tick();
    wb.req_valid = 2'b00;
    rst_ni = 1'b1;
    tick();
    chk_eq("t1_rs1_post", 32'(rs1_busy_o), 32'h0);
    chk_eq("t1_en_post",  32'(rf_write_en_o), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
